twiddle_gen: RTL

- Sequential twiddle-factor generator for the FFT/IFFT butterfly datapath.
- Consumes the per-stage base rotation W_h = (cos, ±sin) produced by the stage cos/sin lookup blocks, quantised to Q(FRAC).
- Streams W_h^k for k = 0 .. h/2-1 to the butterfly unit over a valid/ready handshake.
- Direction (forward/inverse) is carried in the sign of the supplied base_im. The block only tags it through on `dir_out`.

---
 rtl/twiddle_gen_if.sv | 25 ++
 rtl/twiddle_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen_if.sv
// Twiddle stream bundle: w_*/w_idx/w_last/dir_out with valid/ready.
// master drives the stream and samples out_ready; slave is the butterfly side.
interface twiddle_gen_if #(
  parameter int WIDTH = 32
);
  logic signed [WIDTH-1:0] w_re;
  logic signed [WIDTH-1:0] w_im;
  logic [6:0]              w_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    w_last;
  logic                    dir_out;

  modport master (
    output w_re, w_im, w_idx,
    output out_valid, w_last, dir_out,
    input  out_ready
  );

  modport slave (
    input  w_re, w_im, w_idx,
    input  out_valid, w_last, dir_out,
    output out_ready
  );
endinterface

// File: rtl/twiddle_gen.sv
// Sequential twiddle generator: streams W^k, k=0..h/2-1, w = w*base each beat.
// Ports: clk/rst (sync, high), start/on/h/base_re/base_im request,
// busy/err status, wo = twiddle stream (master side of twiddle_gen_if).
module twiddle_gen #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    on,
  input  logic [10:0]             h,
  input  logic signed [WIDTH-1:0] base_re,
  input  logic signed [WIDTH-1:0] base_im,
  output logic                    busy,
  output logic                    err,
  twiddle_gen_if.master           wo
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic signed [WIDTH-1:0] UNITY =
    {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [2*WIDTH:0] RND =
    {{(2*WIDTH-FRAC+2){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] wre_q, wre_d;
  logic signed [WIDTH-1:0] wim_q, wim_d;
  logic signed [WIDTH-1:0] bre_q, bre_d;
  logic signed [WIDTH-1:0] bim_q, bim_d;
  logic [6:0]              idx_q, idx_d;
  logic [6:0]              n_q, n_d;
  logic                    last_q, last_d;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;

  logic                    h_ok;

  always_comb begin
    h_ok = 1'b0;
    unique case (h)
      11'd2, 11'd4, 11'd8, 11'd16,
      11'd32, 11'd64, 11'd128: h_ok = 1'b1;
      default:                 h_ok = 1'b0;
    endcase
  end

  // Full-width complex product of registered w and base only, so the
  // next twiddle never depends combinationally on out_ready.
  logic signed [2*WIDTH-1:0] xr, xi, yr, yi;
  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   s_re, s_im;
  logic signed [WIDTH-1:0]   mul_re, mul_im;

  assign xr = {{WIDTH{wre_q[WIDTH-1]}}, wre_q};
  assign xi = {{WIDTH{wim_q[WIDTH-1]}}, wim_q};
  assign yr = {{WIDTH{bre_q[WIDTH-1]}}, bre_q};
  assign yi = {{WIDTH{bim_q[WIDTH-1]}}, bim_q};

  assign p_rr = xr * yr;
  assign p_ii = xi * yi;
  assign p_ri = xr * yi;
  assign p_ir = xi * yr;

  assign s_re = {p_rr[2*WIDTH-1], p_rr}
              - {p_ii[2*WIDTH-1], p_ii} + RND;
  assign s_im = {p_ri[2*WIDTH-1], p_ri}
              + {p_ir[2*WIDTH-1], p_ir} + RND;

  // Arithmetic shift by FRAC then truncate == take this bit window.
  assign mul_re = s_re[FRAC+WIDTH-1:FRAC];
  assign mul_im = s_im[FRAC+WIDTH-1:FRAC];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wre_q   <= '0;
      wim_q   <= '0;
      bre_q   <= '0;
      bim_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wre_q   <= wre_d;
      wim_q   <= wim_d;
      bre_q   <= bre_d;
      bim_q   <= bim_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && h_ok) state_d = RUN;
      RUN:  if (wo.out_ready && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wre_d  = wre_q;
    wim_d  = wim_q;
    bre_d  = bre_q;
    bim_d  = bim_q;
    idx_d  = idx_q;
    n_d    = n_q;
    last_d = last_q;
    dir_d  = dir_q;
    err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && h_ok) begin
          wre_d  = UNITY;
          wim_d  = '0;
          idx_d  = '0;
          bre_d  = base_re;
          bim_d  = base_im;
          dir_d  = on;
          n_d    = h[7:1];
          last_d = (h[7:1] == 7'd1);
        end else if (start) begin
          err_d  = 1'b1;
        end
      end
      RUN: begin
        if (wo.out_ready) begin
          if (last_q) begin
            last_d = 1'b0;
          end else begin
            wre_d  = mul_re;
            wim_d  = mul_im;
            idx_d  = idx_q + 7'd1;
            // next index is the last one when idx+1 == N-1
            last_d = ((idx_q + 7'd2) == n_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign wo.w_re      = wre_q;
  assign wo.w_im      = wim_q;
  assign wo.w_idx     = idx_q;
  assign wo.w_last    = last_q;
  assign wo.dir_out   = dir_q;
  assign wo.out_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign err          = err_q;

endmodule
